// File: rtl/iagc_heartbeat.sv
// Heartbeat generator for the IAGC watchdog gate: while status is IDLE and enabled,
// emits PULSE_WIDTH-cycle pulses every PERIOD cycles, with an optional immediate kick.
module iagc_heartbeat #(
  parameter int unsigned                  IAGC_STATUS_SIZE = 4,
  parameter logic [IAGC_STATUS_SIZE-1:0]  STATUS_IDLE      = 4'b0010,
  parameter int unsigned                  PERIOD           = 8,
  parameter int unsigned                  PULSE_WIDTH      = 2,
  parameter int unsigned                  STARTUP_DELAY    = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagcStatus,
  input  logic                        i_enable,
  input  logic                        i_kick,
  output logic                        o_gate,
  output logic                        o_active,
  output logic [7:0]                  o_beatCount
);

  typedef enum logic [1:0] {
    S_OFF,
    S_WAIT,
    S_HIGH,
    S_LOW
  } state_t;

  // WAIT spans STARTUP_DELAY+1 cycles so that STARTUP_DELAY=0 still yields one WAIT cycle.
  localparam logic [7:0] WAIT_LAST = 8'(STARTUP_DELAY);
  localparam logic [7:0] HIGH_LAST = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] LOW_LAST  = 8'(PERIOD - PULSE_WIDTH - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_gate;
  logic       r_active;
  logic [7:0] r_beatCount;

  logic       w_run;
  logic       w_waitDone;
  logic       w_highDone;
  logic       w_lowDone;

  assign w_run      = (i_iagcStatus == STATUS_IDLE) && i_enable;
  assign w_waitDone = (r_cnt == WAIT_LAST);
  assign w_highDone = (r_cnt == HIGH_LAST);
  assign w_lowDone  = (r_cnt == LOW_LAST);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_gate      <= 1'b0;
      r_active    <= 1'b0;
      r_beatCount <= '0;
    end else if (!w_run) begin
      // Losing run overrides everything, including a pending kick or a pulse in progress.
      r_state  <= S_OFF;
      r_cnt    <= '0;
      r_gate   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_state  <= S_WAIT;
          r_cnt    <= '0;
          r_gate   <= 1'b0;
          r_active <= 1'b1;
        end
        S_WAIT, S_LOW: begin
          if (i_kick || (r_state == S_WAIT ? w_waitDone : w_lowDone)) begin
            r_state     <= S_HIGH;
            r_cnt       <= '0;
            r_gate      <= 1'b1;
            r_beatCount <= r_beatCount + 8'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (w_highDone) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_gate  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= S_OFF;
          r_cnt    <= '0;
          r_gate   <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_gate      = r_gate;
  assign o_active    = r_active;
  assign o_beatCount = r_beatCount;

endmodule
